muldiv_unit: RTL and testbench

//   Multi-cycle signed multiply/divide engine on the datapath. Sits downstream of the control FSM.
//   The mul/div states load operand A from Y and operand B from the bus, then pulse start.
//   The control FSM holds until done; it then moves the product or quotient/remainder to LO/HI
//   via the Z path. Replaces the single-cycle combinational mul/div in the ALU.

---
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle signed multiply / divide engine.
//
// A request is accepted on a rising edge where start=1 and busy=0. Operands
// are reduced to sign plus WIDTH+1-bit magnitude, one iteration runs per
// clock for WIDTH clocks, then a fix-up cycle applies the signs and writes the
// results. The fix-up edge raises done for exactly one cycle.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high; aborts an operation without done
//   start        request, sampled only while busy=0
//   op           0 = signed multiply, 1 = signed divide (a / b)
//   operand_a    multiplicand / dividend
//   operand_b    multiplier / divisor
//   busy         operation in progress (low in the done cycle)
//   done         one-cycle pulse, results valid
//   result_hi    mul: product[2W-1:W]; div: remainder
//   result_lo    mul: product[W-1:0];  div: quotient
//   div_by_zero  set with done for a divide by zero, cleared on next accept
//   fsm_state    current FSM state (IDLE=0, CALC=1, FIX=2), debug only
//
// Handshake: start/busy is a valid/ready pair with ready = !busy. A request
// transfers on a rising edge where start=1 and busy=0; nothing else is
// sampled. done is a one-cycle valid with no back-pressure.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t          state;
  state_t          state_next;

  logic            op_r;
  logic            sign_a;
  logic            sign_b;
  logic [WIDTH:0]  mag_a;
  logic [WIDTH:0]  mag_b;
  logic [CW-1:0]   count;
  // acc_hi/acc_lo are the running product (mul) or remainder/quotient (div).
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_b;
  logic [WIDTH:0]   abs_a;
  logic [WIDTH:0]   abs_b;
  logic             last_step;

  logic [WIDTH+1:0] mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;

  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot_signed;
  logic [WIDTH-1:0]   rem_signed;
  logic [WIDTH-1:0]   a_raw;

  // Sign-extend by one bit so that |-2^(W-1)| fits in the magnitude.
  assign ext_a = {operand_a[WIDTH-1], operand_a};
  assign ext_b = {operand_b[WIDTH-1], operand_b};
  assign abs_a = operand_a[WIDTH-1] ? -ext_a : ext_a;
  assign abs_b = operand_b[WIDTH-1] ? -ext_b : ext_b;

  assign last_step = (count == CW'(WIDTH - 1));

  // Multiply step: conditionally add |a| into the upper half, shift right.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);

  // Restoring divide step: shift the next dividend bit in, trial-subtract.
  // The remainder stays below |b| <= 2^(W-1), so the shift cannot overflow.
  assign div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {1'b0, mag_b};

  assign prod_mag    = {acc_hi[WIDTH-1:0], acc_lo};
  assign prod_signed = (sign_a ^ sign_b) ? -prod_mag : prod_mag;
  assign quot_signed = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
  assign rem_signed  = sign_a ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
  // Original dividend, rebuilt for the divide-by-zero result.
  assign a_raw       = sign_a ? -mag_a[WIDTH-1:0] : mag_a[WIDTH-1:0];

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_r        <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      count       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      done        <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r        <= op;
            sign_a      <= operand_a[WIDTH-1];
            sign_b      <= operand_b[WIDTH-1];
            mag_a       <= abs_a;
            mag_b       <= abs_b;
            count       <= '0;
            acc_hi      <= '0;
            // Multiply shifts the multiplier out; divide shifts the dividend.
            acc_lo      <= op ? abs_a[WIDTH-1:0] : abs_b[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (!op_r) begin
            acc_hi <= mul_sum[WIDTH+1:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end else if (!div_diff[WIDTH+1]) begin
            acc_hi <= div_diff[WIDTH:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift;
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (!op_r) begin
            result_hi <= prod_signed[2*WIDTH-1:WIDTH];
            result_lo <= prod_signed[WIDTH-1:0];
          end else if (mag_b == '0) begin
            result_hi   <= a_raw;
            result_lo   <= '1;
            div_by_zero <= 1'b1;
          end else begin
            result_hi <= rem_signed;
            result_lo <= quot_signed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors with hand-computed results.
// The driver pushes {div_by_zero, hi, lo} into exp_q on each accepted start;
// the monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;

  logic         clock;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result_hi;
  logic [W-1:0] result_lo;
  logic         div_by_zero;
  logic [1:0]   fsm_state;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .div_by_zero (div_by_zero),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [2*W:0] exp_q[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int accept_cyc = 0;
  int done_count = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Call just after a falling edge; returns 1 time unit after the accept edge.
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W:0] exp);
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start      = 1'b0;
    accept_cyc = cyc;
    exp_q.push_back(exp);
    // Operands are free to change after the accept edge.
    operand_a = $urandom;
    operand_b = $urandom;
    op        = 1'($urandom_range(0, 1));
  endtask

  // Returns at the falling edge where done is high.
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done not seen within 100 cycles", name);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset && done) begin
      logic [2*W:0] exp;
      done_count++;
      check("done_not_double", {64'd0, prev_done}, '0);
      check("busy_low_in_done", {64'd0, busy}, '0);
      check("latency", (2*W+1)'(cyc - accept_cyc), (2*W+1)'(LATENCY));
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty queue, expected none");
      end else begin
        exp = exp_q.pop_front();
        check("result", {div_by_zero, result_hi, result_lo}, exp);
      end
    end
    prev_done = done;
  end

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    reset     = 1'b1;
    start     = 1'b0;
    op        = 1'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_state", {30'd0, busy, done, div_by_zero, result_hi, result_lo}, '0);
    reset = 1'b0;

    // 1: 7 * -3 = -21
    @(negedge clock);
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    check("busy_after_accept", {64'd0, busy}, 65'd1);
    wait_done("t1");

    // 2: (-2^31) * (-2^31) = 2^62
    @(negedge clock);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, {1'b0, 32'h4000_0000, 32'h0000_0000});
    wait_done("t2");

    // 3: -17 / 5 -> q=-3, r=-2
    @(negedge clock);
    issue(1'b1, 32'hFFFF_FFEF, 32'd5, {1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFD});
    wait_done("t3");

    // 4: 100 / 0
    @(negedge clock);
    issue(1'b1, 32'd100, 32'd0, {1'b1, 32'd100, 32'hFFFF_FFFF});
    wait_done("t4");
    @(negedge clock);
    check("dbz_held", {64'd0, div_by_zero}, 65'd1);

    // 5: 50 / 7 -> q=7, r=1; second start mid-operation is ignored
    issue(1'b1, 32'd50, 32'd7, {1'b0, 32'd1, 32'd7});
    check("dbz_cleared_on_accept", {64'd0, div_by_zero}, '0);
    dc = done_count;
    while (cyc < accept_cyc + 10) @(negedge clock);
    op        = 1'b0;
    operand_a = 32'd9;
    operand_b = 32'd2;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_during_ignored_start", {64'd0, busy}, 65'd1);
    wait_done("t5");
    repeat (40) @(negedge clock);
    check("t5_done_once", (2*W+1)'(done_count - dc), 65'd1);

    // Extra boundary vectors
    @(negedge clock);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'h0, 32'h1});
    wait_done("mul_m1_m1");
    @(negedge clock);
    issue(1'b0, 32'h7FFF_FFFF, 32'd2, {1'b0, 32'h0, 32'hFFFF_FFFE});
    wait_done("mul_max_2");
    @(negedge clock);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0, 32'h8000_0000});
    wait_done("div_min_m1");
    @(negedge clock);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, {1'b0, 32'd1, 32'hFFFF_FFFD});
    wait_done("div_7_m2");

    // 6: reset mid-operation aborts without done
    @(negedge clock);
    issue(1'b0, 32'd5, 32'd6, {1'b0, 32'd0, 32'd30});
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_abort_outputs", {30'd0, busy, done, div_by_zero, result_hi, result_lo}, '0);
    void'(exp_q.pop_back());
    @(negedge clock);
    reset = 1'b0;
    dc = done_count;
    repeat (40) @(negedge clock);
    check("no_done_after_abort", (2*W+1)'(done_count - dc), '0);

    // Back-to-back: start again in the done cycle
    issue(1'b0, 32'd3, 32'd4, {1'b0, 32'd0, 32'd12});
    wait_done("b2b_first");
    issue(1'b0, 32'hFFFF_FFFE, 32'd3, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    check("done_cleared_on_b2b_accept", {63'd0, done, busy}, 65'd1);
    wait_done("b2b_second");

    @(negedge clock);
    check("queue_drained", (2*W+1)'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
